// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among 8 requesters. The owner holds the grant
// until the ALU signals done, the owner drops its request, or the watchdog expires.
module alu_rr_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic [7:0] grant_onehot,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam bit          WDOG_EN = (TIMEOUT != 0);
  // With the watchdog off the counter still stops at all-ones rather than wrapping.
  localparam int unsigned SAT_INT = WDOG_EN ? (TIMEOUT - 1) : ((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SAT_INT);

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [7:0]       onehot_q, onehot_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       winner;

  // First set bit of r, searching p, p+1, ..., p+7 with 3-bit wrap.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign winner = rr_pick(req, ptr_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE, RELEASE: begin
        if (|req) begin
          state_d = BUSY;
          idx_d   = winner;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        valid_d = 1'b1;
        if (done || !req[idx_q] || (WDOG_EN && cnt_q == CNT_SAT)) begin
          state_d   = RELEASE;
          valid_d   = 1'b0;
          ptr_d     = idx_q + 3'd1;
          cnt_d     = '0;
          timeout_d = WDOG_EN && !done && req[idx_q];
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    onehot_d = valid_d ? (8'b1 << idx_d) : 8'b0;
    busy_d   = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      onehot_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      onehot_q  <= onehot_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign busy         = busy_q;
  assign timeout      = timeout_q;

endmodule
